// File: rtl/i2so_clk_ctrl.sv
// I2S output clock sequencer: divides clk down to sck, emits rise/fall strobes,
// tracks the bit position in a 32-bit stereo frame and starts/stops output
// only on frame boundaries. Completed frames are counted for status readback.
module i2so_clk_ctrl #(
  parameter int DIV_W  = 8,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              trig_frame_clr,
  output logic              i2so_sck,
  output logic              i2so_sck_rise,
  output logic              i2so_sck_transition,
  output logic [4:0]        i2so_bit_cnt,
  output logic              i2so_frame_start,
  output logic              i2so_active,
  output logic [FCNT_W-1:0] ro_frame_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sck_q, sck_d;
  logic               rise_q, rise_d;
  logic               trans_q, trans_d;
  logic               fs_q, fs_d;
  logic               active_q, active_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // tick: the divider reaches its terminal count and sck toggles on the next edge
  logic tick;
  // frame_end: the falling-edge strobe for the last bit of the frame is on the line
  logic frame_end;

  assign tick      = (state_q != IDLE) && (div_cnt_q == div_q);
  assign frame_end = trans_q && (bit_cnt_q == 5'd31);

  // Next-state logic; divider ratio is captured only on IDLE->RUN entry
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d = RUN;
          div_d   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        end
      end
      RUN: begin
        if (!cfg_en) state_d = STOP;
      end
      STOP: begin
        // frame end wins over a late re-enable; restart then goes through IDLE
        if (frame_end)   state_d = IDLE;
        else if (cfg_en) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider, sck edges, bit position, frame start and frame counter
  always_comb begin
    div_cnt_d   = div_cnt_q;
    sck_d       = sck_q;
    rise_d      = 1'b0;
    trans_d     = 1'b0;
    fs_d        = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d = '0;
        sck_d     = ~sck_q;
        rise_d    = ~sck_q;
        trans_d   = sck_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end

    // bit position advances after the serializer has seen the fall strobe
    if (trans_q) bit_cnt_d = bit_cnt_q + 5'd1;

    if (frame_end)      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    if (trig_frame_clr) frame_cnt_d = '0;

    // frame start: on entry, and alongside the bit-31 fall strobe if still running
    if ((state_q == IDLE) && (state_d == RUN)) fs_d = 1'b1;
    if (tick && sck_q && (bit_cnt_q == 5'd31) && (state_d == RUN)) fs_d = 1'b1;

    if (state_d == IDLE) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
      rise_d    = 1'b0;
      trans_d   = 1'b0;
      bit_cnt_d = '0;
    end

    active_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      div_cnt_q   <= '0;
      sck_q       <= 1'b0;
      rise_q      <= 1'b0;
      trans_q     <= 1'b0;
      fs_q        <= 1'b0;
      active_q    <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      sck_q       <= sck_d;
      rise_q      <= rise_d;
      trans_q     <= trans_d;
      fs_q        <= fs_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign i2so_sck            = sck_q;
  assign i2so_sck_rise       = rise_q;
  assign i2so_sck_transition = trans_q;
  assign i2so_bit_cnt        = bit_cnt_q;
  assign i2so_frame_start    = fs_q;
  assign i2so_active         = active_q;
  assign ro_frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_i2so_clk_ctrl.sv
// Bench for i2so_clk_ctrl: stimulus pushes expected strobe events (frame
// start, sck rise, sck fall) with hand-derived cycle numbers; a monitor pops
// and compares them as the DUT raises its strobes.
module tb_i2so_clk_ctrl;
  localparam int DIV_W  = 8;
  localparam int FCNT_W = 16;
  localparam int K_FS = 0, K_RISE = 1, K_TRANS = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_en = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              trig_frame_clr = 1'b0;
  logic              i2so_sck, i2so_sck_rise, i2so_sck_transition;
  logic [4:0]        i2so_bit_cnt;
  logic              i2so_frame_start, i2so_active;
  logic [FCNT_W-1:0] ro_frame_cnt;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int cyc;
    int bits;
    int sck;
    int fcnt;
  } ev_t;
  ev_t exp_q[$];

  i2so_clk_ctrl #(.DIV_W(DIV_W), .FCNT_W(FCNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_en              (cfg_en),
    .cfg_div             (cfg_div),
    .trig_frame_clr      (trig_frame_clr),
    .i2so_sck            (i2so_sck),
    .i2so_sck_rise       (i2so_sck_rise),
    .i2so_sck_transition (i2so_sck_transition),
    .i2so_bit_cnt        (i2so_bit_cnt),
    .i2so_frame_start    (i2so_frame_start),
    .i2so_active         (i2so_active),
    .ro_frame_cnt        (ro_frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int bits, input int sck, input int fc);
    ev_t e;
    e = '{kind, c, bits, sck, fc};
    exp_q.push_back(e);
  endtask

  // One frame entered at cycle e with divider d: half-period d+1, period P.
  // Rise of bit b at e+b*P+d+1, fall strobe at e+(b+1)*P while bit_cnt still shows b.
  task automatic push_frame(input int e, input int d, input int fc, input int nbits, input bit wrap);
    int p;
    p = 2 * (d + 1);
    for (int b = 0; b < nbits; b++) begin
      push_ev(K_RISE, e + b * p + d + 1, b, 1, fc);
      if (b == 31 && wrap) push_ev(K_FS, e + 32 * p, 31, 0, fc);
      push_ev(K_TRANS, e + (b + 1) * p, b, 0, fc);
    end
  endtask

  function automatic bit strobe(input int k);
    if (k == K_FS)   return i2so_frame_start;
    if (k == K_RISE) return i2so_sck_rise;
    return i2so_sck_transition;
  endfunction

  // Monitor: flag overdue expectations, then match each raised strobe in order
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL sb_missing kind=%0d: no strobe seen, required at cyc %0d (now %0d)",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        if (strobe(k)) begin
          ev_t a, e;
          a = '{k, cyc, int'(i2so_bit_cnt), int'(i2so_sck), int'(ro_frame_cnt)};
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected kind=%0d at cyc %0d: got strobe, required none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (a.kind != e.kind || a.cyc != e.cyc || a.bits != e.bits ||
                a.sck != e.sck || a.fcnt != e.fcnt) begin
              fails++;
              $display("FAIL sb_event: got kind=%0d cyc=%0d bit=%0d sck=%0d fcnt=%0d required kind=%0d cyc=%0d bit=%0d sck=%0d fcnt=%0d",
                       a.kind, a.cyc, a.bits, a.sck, a.fcnt, e.kind, e.cyc, e.bits, e.sck, e.fcnt);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sck"},    int'(i2so_sck), 0);
    chk({tag, "_rise"},   int'(i2so_sck_rise), 0);
    chk({tag, "_trans"},  int'(i2so_sck_transition), 0);
    chk({tag, "_bitcnt"}, int'(i2so_bit_cnt), 0);
    chk({tag, "_fs"},     int'(i2so_frame_start), 0);
    chk({tag, "_active"}, int'(i2so_active), 0);
    chk({tag, "_fcnt"},   int'(ro_frame_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e;
    // reset state
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(2);
    chk("idle_active", int'(i2so_active), 0);

    // div=1: period 4, one full frame, then stop requested at bit 10
    cfg_div = 8'd1;
    cfg_en  = 1'b1;
    e = cyc + 1;
    push_ev(K_FS, e, 0, 0, 0);
    push_frame(e, 1, 0, 32, 1'b1);
    push_frame(e + 128, 1, 1, 32, 1'b0);
    to_cyc(e + 128 + 10 * 4 + 2);
    cfg_en = 1'b0;
    to_cyc(e + 128 + 20 * 4);
    chk("stop_active", int'(i2so_active), 1);
    to_cyc(e + 257);
    chk("t1_idle_active", int'(i2so_active), 0);
    chk("t1_idle_sck", int'(i2so_sck), 0);
    chk("t1_idle_bitcnt", int'(i2so_bit_cnt), 0);
    chk("t1_fcnt", int'(ro_frame_cnt), 2);

    // clear in IDLE, then div=3 for 3 frames with a short stop/resume in frame 1
    trig_frame_clr = 1'b1;
    step(1);
    trig_frame_clr = 1'b0;
    chk("clr_idle_fcnt", int'(ro_frame_cnt), 0);
    cfg_div = 8'd3;
    cfg_en  = 1'b1;
    e = cyc + 1;
    push_ev(K_FS, e, 0, 0, 0);
    push_frame(e, 3, 0, 32, 1'b1);
    push_frame(e + 256, 3, 1, 32, 1'b1);
    push_frame(e + 512, 3, 2, 32, 1'b0);
    to_cyc(e + 50);
    cfg_div = 8'd7;
    to_cyc(e + 256 + 5 * 8 + 2);
    cfg_en = 1'b0;
    to_cyc(e + 256 + 8 * 8 + 2);
    cfg_en = 1'b1;
    to_cyc(e + 512 + 20 * 8 + 2);
    cfg_en = 1'b0;
    to_cyc(e + 769);
    chk("t2_fcnt", int'(ro_frame_cnt), 3);
    chk("t2_idle_active", int'(i2so_active), 0);
    chk("t2_idle_sck", int'(i2so_sck), 0);

    // div=0 behaves as 1; a mid-run change to 7 is held off
    cfg_div = 8'd0;
    cfg_en  = 1'b1;
    e = cyc + 1;
    push_ev(K_FS, e, 0, 0, 3);
    push_frame(e, 1, 3, 32, 1'b1);
    push_frame(e + 128, 1, 4, 32, 1'b0);
    to_cyc(e + 128 + 3 * 4 + 2);
    cfg_div = 8'd7;
    to_cyc(e + 128 + 10 * 4 + 2);
    cfg_en = 1'b0;
    to_cyc(e + 257);
    chk("t3_fcnt", int'(ro_frame_cnt), 5);
    chk("t3_idle_active", int'(i2so_active), 0);

    // restart picks up div=7 (period 16); clear coincident with frame end; reset mid-frame
    cfg_en = 1'b1;
    e = cyc + 1;
    push_ev(K_FS, e, 0, 0, 5);
    push_frame(e, 7, 5, 32, 1'b1);
    push_frame(e + 512, 7, 6, 32, 1'b1);
    push_frame(e + 1024, 7, 0, 4, 1'b0);
    to_cyc(e + 1024);
    trig_frame_clr = 1'b1;
    step(1);
    trig_frame_clr = 1'b0;
    chk("clr_wins_fcnt", int'(ro_frame_cnt), 0);
    to_cyc(e + 1024 + 4 * 16 + 3);
    chk("pre_reset_bitcnt", int'(i2so_bit_cnt), 4);
    rst_n  = 1'b0;
    cfg_en = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_active", int'(i2so_active), 0);
    chk("post_rst_sck", int'(i2so_sck), 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2so_clk_ctrl.md
Name: i2so_clk_ctrl

Overview:
Sequencer for the I2S output datapath. Generates the serial clock from clk with a programmable divider, and emits the single-cycle falling-edge pulse that the serializer shifts on. Tracks bit position within a 32-bit stereo frame (16 left + 16 right). Starts and stops the output only on frame boundaries, so a partial frame never reaches the codec, and counts completed frames for status readback.

Parameters:
DIV_W, 8, width of cfg_div.
FCNT_W, 16, width of ro_frame_cnt.

Ports:
clk  input  1  master clock
rst_n  input  1  reset, asynchronous, active-low
cfg_en  input  1  level; 1 = run I2S output, 0 = stop at the next frame end
cfg_div  input  DIV_W  sck half-period in clk cycles minus 1; 0 is treated as 1
trig_frame_clr  input  1  single-cycle pulse; clears ro_frame_cnt
i2so_sck  output  1  serial clock, registered
i2so_sck_rise  output  1  one-clk pulse in the cycle sck goes 0->1
i2so_sck_transition  output  1  one-clk pulse in the cycle sck goes 1->0; serializer shift strobe
i2so_bit_cnt  output  5  index of the bit currently on the line, 0..31
i2so_frame_start  output  1  one-clk pulse marking the start of a frame
i2so_active  output  1  high in RUN and STOP
ro_frame_cnt  output  FCNT_W  completed-frame count, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All of the following are 0: i2so_sck, both pulses, i2so_bit_cnt, i2so_frame_start, i2so_active, ro_frame_cnt, div_cnt, div_q. Reset asserted mid-frame aborts immediately; there is no drain.
- States: IDLE, RUN, STOP.
- IDLE:
  - sck=0, div_cnt=0, bit_cnt=0.
  - If cfg_en=1: latch div_q = max(cfg_div,1), go to RUN, and pulse i2so_frame_start in that same cycle.
- Divider (RUN/STOP):
  - div_cnt increments each clk.
  - When div_cnt==div_q: div_cnt<=0 and sck toggles.
  - sck period = 2*(div_q+1) clk; minimum is 4 clk.
  - First rise occurs div_q+1 clk after entry to RUN.
- Pulses:
  - i2so_sck_rise and i2so_sck_transition are asserted in the same cycle as the registered sck edge.
  - They are mutually exclusive and never asserted in IDLE.
- Bit counter:
  - On each transition pulse, bit_cnt <= bit_cnt+1, wrapping 31->0.
  - The transition pulse with bit_cnt==31 is the frame end. On that pulse, ro_frame_cnt increments, and in RUN i2so_frame_start pulses in the same cycle.
- RUN -> STOP when cfg_en=0. Clocks continue.
- STOP:
  - cfg_en=1 before frame end: return to RUN seamlessly, with no phase or bit_cnt disturbance.
  - Frame end while in STOP: go to IDLE. sck is already 0; no frame_start pulse.
- cfg_div changes while not IDLE are ignored until the next IDLE->RUN entry.
- trig_frame_clr coincident with a frame-end increment: the clear wins, and ro_frame_cnt=0.
- ro_frame_cnt wraps from all-ones to 0.
- i2so_active = (state!=IDLE), registered.

Test Plan:
- Reset, then cfg_div=1, cfg_en=1 -> frame_start at entry cycle; sck high 2 clk / low 2 clk (period 4); first rise at clk 2 after entry; transition pulse every 4 clk.
- Run 3 frames with cfg_div=3 -> 32 transition pulses per frame (256 clk per frame); bit_cnt 0..31 wraps; frame_start at each wrap; ro_frame_cnt=3.
- cfg_en dropped at bit_cnt=10 -> output continues until bit_cnt=31 falls; then IDLE with sck=0, active=0, ro_frame_cnt +1 and no extra frame_start.
- cfg_en dropped at bit_cnt=5 and reasserted at bit_cnt=8 -> no gap, no phase change, frame_start at the normal wrap.
- cfg_div=0 -> behaves as 1 (period 4). Changing cfg_div to 7 mid-run has no effect until stop/restart, after which the period is 16.
- trig_frame_clr in the same cycle as a frame end -> ro_frame_cnt=0. Async rst_n mid-frame -> all outputs 0 immediately.
